// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: req/ready data bus access with byte-lane steering,
// load extraction/extension, writeback select and the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        regwrite_EX,
  input  logic        datawe_EX,
  input  logic [2:0]  wbsel_EX,
  input  logic [2:0]  strb_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] aluout_EX,
  input  logic [31:0] rdata2_EX,
  input  logic [31:0] immext_EX,
  input  logic [31:0] pcimmaui_EX,
  input  logic [31:0] pcnext_EX,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ready,
  output logic        stall_MEM,
  output logic        regwrite_MEM,
  output logic [4:0]  rd_MEM,
  output logic [31:0] wbdata_MEM,
  output logic        misalign_MEM,
  output logic        buserr_MEM
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_acc;
  logic        w_mis;
  logic        w_timeout;
  logic        w_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wbdata;

  assign w_acc = datawe_EX | (wbsel_EX == 3'b001);

  always_comb begin
    w_mis = 1'b0;
    if (strb_EX[1:0] == 2'b01)
      w_mis = w_acc & aluout_EX[0];
    else if (strb_EX == 3'b010)
      w_mis = w_acc & (aluout_EX[1:0] != 2'b00);
  end

  assign w_timeout = (r_state == S_WAIT) & ~dbus_ready &
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  // Reset gates the request so an async reset mid-access drops it in the same cycle.
  assign w_req     = rstn & w_acc & ~w_mis & ~w_timeout;
  assign dbus_req  = w_req;
  assign dbus_we   = w_req & datawe_EX;
  assign stall_MEM = w_req & ~dbus_ready;
  assign dbus_addr = {aluout_EX[31:2], 2'b00};

  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = rdata2_EX;
    case (strb_EX)
      3'b000, 3'b100: begin
        dbus_be    = 4'b0001 << aluout_EX[1:0];
        dbus_wdata = {4{rdata2_EX[7:0]}};
      end
      3'b001, 3'b101: begin
        dbus_be    = aluout_EX[1] ? 4'b1100 : 4'b0011;
        dbus_wdata = {2{rdata2_EX[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (aluout_EX[1:0])
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half = aluout_EX[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (strb_EX)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = dbus_rdata;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  always_comb begin
    case (wbsel_EX)
      3'b000:  w_wbdata = aluout_EX;
      3'b001:  w_wbdata = w_load;
      3'b010:  w_wbdata = pcnext_EX;
      3'b011:  w_wbdata = immext_EX;
      3'b100:  w_wbdata = pcimmaui_EX;
      default: w_wbdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !dbus_ready) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (dbus_ready || w_timeout) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // MEM/WB: bubble while stalled, flagged no-write on misalign/timeout, else normal completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regwrite_MEM <= 1'b0;
      rd_MEM       <= '0;
      wbdata_MEM   <= '0;
      misalign_MEM <= 1'b0;
      buserr_MEM   <= 1'b0;
    end else if (stall_MEM) begin
      regwrite_MEM <= 1'b0;
      misalign_MEM <= 1'b0;
      buserr_MEM   <= 1'b0;
    end else if (w_mis) begin
      regwrite_MEM <= 1'b0;
      rd_MEM       <= rd_EX;
      wbdata_MEM   <= '0;
      misalign_MEM <= 1'b1;
      buserr_MEM   <= 1'b0;
    end else if (w_timeout) begin
      regwrite_MEM <= 1'b0;
      rd_MEM       <= rd_EX;
      wbdata_MEM   <= '0;
      misalign_MEM <= 1'b0;
      buserr_MEM   <= 1'b1;
    end else begin
      regwrite_MEM <= regwrite_EX;
      rd_MEM       <= rd_EX;
      wbdata_MEM   <= w_wbdata;
      misalign_MEM <= 1'b0;
      buserr_MEM   <= 1'b0;
    end
  end

endmodule
